// File: rtl/div_restoring_pkg.sv
// div_restoring_pkg
// Shared definitions for the restoring divider slice: FSM state encoding,
// operand-select codes for the single-bus loader, and the quotient value
// reported when the divisor is zero.
package div_restoring_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SEL_DIVD_LO = 2'd0,
        SEL_DIVD_HI = 2'd1,
        SEL_DIVR    = 2'd2,
        SEL_NONE    = 2'd3
    } sel_t;

    // Wide enough for any practical size; users slice off 2*size bits.
    localparam logic [63:0] DBZ_QUOTIENT = '1;

endpackage

// File: rtl/div_restoring_if.sv
// div_restoring_if
// Operand-load and result bus of the restoring divider.
//   start        begin a division with the held operands
//   sel, set     operand select and active-low write strobe
//   currIn       operand data
//   busy, done   handshake (done is a one-cycle pulse)
//   div_by_zero  divisor was zero for the last result
//   quotient     2*size-bit result, remainder size-bit result
// master: the side that loads operands; slave: the divider.
interface div_restoring_if #(parameter int size = 8);

    logic                  start;
    logic [1:0]            sel;
    logic                  set;
    logic [size-1:0]       currIn;
    logic                  busy;
    logic                  done;
    logic                  div_by_zero;
    logic [2*size-1:0]     quotient;
    logic [size-1:0]       remainder;

    modport master (
        output start, sel, set, currIn,
        input  busy, done, div_by_zero, quotient, remainder
    );

    modport slave (
        input  start, sel, set, currIn,
        output busy, done, div_by_zero, quotient, remainder
    );

endinterface

// File: rtl/div_restoring_core.sv
// div_core
// Iterative restoring divider, one quotient bit per clock.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   start                  begin a division (honoured only in IDLE)
//   dividend, divisor      operands, snapshotted on an accepted start
//   busy, done             RUN-state flag, one-cycle completion pulse
//   div_by_zero            last accepted start had a zero divisor
//   quotient, remainder    result registers, updated when done rises
module div_core
    import div_restoring_pkg::*;
#(
    parameter int size = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [2*size-1:0]   dividend,
    input  logic [size-1:0]     divisor,
    output logic                busy,
    output logic                done,
    output logic                div_by_zero,
    output logic [2*size-1:0]   quotient,
    output logic [size-1:0]     remainder
);

    localparam int            CW   = $clog2(2*size) + 1;
    localparam logic [CW-1:0] LAST = CW'(2*size - 1);

    state_t              state, state_next;
    logic [CW-1:0]       count;
    // Dividend bits shift out of the top while quotient bits shift in at
    // the bottom, so after 2*size steps this register holds the quotient.
    logic [2*size-1:0]   dq;
    logic [size-1:0]     dvsr;
    logic [size-1:0]     r;
    logic [size:0]       r_shift;
    logic [size-1:0]     r_diff;
    logic                fits;
    logic [size-1:0]     r_next;

    // Trial subtraction for the current step. The difference only needs
    // size bits because it is used solely when r_shift >= divisor.
    always_comb begin
        r_shift = {r, dq[2*size-1]};
        r_diff  = r_shift[size-1:0] - dvsr;
        fits    = (r_shift >= {1'b0, dvsr});
        r_next  = fits ? r_diff : r_shift[size-1:0];
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next state and handshake outputs.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start)
                    state_next = (divisor == '0) ? DONE : RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (count == LAST)
                    state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: snapshot on start, iterate in RUN, latch results on the
    // final iteration (or immediately for a zero divisor).
    always_ff @(posedge clk) begin
        if (rst) begin
            count       <= '0;
            dq          <= '0;
            dvsr        <= '0;
            r           <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        count <= '0;
                        dq    <= dividend;
                        dvsr  <= divisor;
                        r     <= '0;
                        if (divisor == '0) begin
                            quotient    <= DBZ_QUOTIENT[2*size-1:0];
                            remainder   <= dividend[size-1:0];
                            div_by_zero <= 1'b1;
                        end else begin
                            div_by_zero <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    count <= count + 1'b1;
                    dq    <= {dq[2*size-2:0], fits};
                    r     <= r_next;
                    if (count == LAST) begin
                        quotient  <= {dq[2*size-2:0], fits};
                        remainder <= r_next;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/div_restoring.sv
// div_restoring
// Top of the restoring divider: operand registers loaded over a single
// select-and-set bus, the iterative core, and optional hex display.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   bus             div_restoring_if slave (start/sel/set/currIn in,
//                   busy/done/div_by_zero/quotient/remainder out)
//   disp0..disp3    active-low seven-segment patterns of quotient[15:0],
//                   disp0 = most-significant nibble
// Build option DIV_HEX_DISPLAY_EN: when defined, four hexSevenSegmentDecoder
// instances drive the displays; otherwise all displays are blank (8'hFF).

`ifdef DIV_HEX_DISPLAY_EN
// Active-low segments, bit order {dp, g, f, e, d, c, b, a}.
module hexSevenSegmentDecoder (
    input  logic [3:0] nibble,
    output logic [7:0] segments
);
    always_comb begin
        segments = 8'hFF;
        case (nibble)
            4'h0: segments = 8'hC0;
            4'h1: segments = 8'hF9;
            4'h2: segments = 8'hA4;
            4'h3: segments = 8'hB0;
            4'h4: segments = 8'h99;
            4'h5: segments = 8'h92;
            4'h6: segments = 8'h82;
            4'h7: segments = 8'hF8;
            4'h8: segments = 8'h80;
            4'h9: segments = 8'h90;
            4'hA: segments = 8'h88;
            4'hB: segments = 8'h83;
            4'hC: segments = 8'hC6;
            4'hD: segments = 8'hA1;
            4'hE: segments = 8'h86;
            4'hF: segments = 8'h8E;
            default: segments = 8'hFF;
        endcase
    end
endmodule
`endif

module div_restoring
    import div_restoring_pkg::*;
#(
    parameter int size = 8
) (
    input  logic             clk,
    input  logic             rst,
    div_restoring_if.slave   bus,
    output logic [7:0]       disp0,
    output logic [7:0]       disp1,
    output logic [7:0]       disp2,
    output logic [7:0]       disp3
);

    logic [2*size-1:0] dividend;
    logic [size-1:0]   divisor;

    // Operand registers stay writable during a division; the core works
    // from its own snapshot so mid-run writes cannot disturb it.
    always_ff @(posedge clk) begin
        if (rst) begin
            dividend <= '0;
            divisor  <= '0;
        end else if (!bus.set) begin
            case (sel_t'(bus.sel))
                SEL_DIVD_LO: dividend[size-1:0]      <= bus.currIn;
                SEL_DIVD_HI: dividend[2*size-1:size] <= bus.currIn;
                SEL_DIVR:    divisor                 <= bus.currIn;
                default: ;
            endcase
        end
    end

    div_core #(.size(size)) u_core (
        .clk         (clk),
        .rst         (rst),
        .start       (bus.start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (bus.busy),
        .done        (bus.done),
        .div_by_zero (bus.div_by_zero),
        .quotient    (bus.quotient),
        .remainder   (bus.remainder)
    );

`ifdef DIV_HEX_DISPLAY_EN
    hexSevenSegmentDecoder u_hex0 (.nibble(bus.quotient[15:12]), .segments(disp0));
    hexSevenSegmentDecoder u_hex1 (.nibble(bus.quotient[11:8]),  .segments(disp1));
    hexSevenSegmentDecoder u_hex2 (.nibble(bus.quotient[7:4]),   .segments(disp2));
    hexSevenSegmentDecoder u_hex3 (.nibble(bus.quotient[3:0]),   .segments(disp3));
`else
    assign disp0 = 8'hFF;
    assign disp1 = 8'hFF;
    assign disp2 = 8'hFF;
    assign disp3 = 8'hFF;
`endif

endmodule

// File: tb/tb_div_restoring.sv
// tb_div_restoring
// Self-checking bench for div_restoring (size = 8): a table of directed
// division vectors plus hand-written sequences for start-while-busy,
// mid-run operand writes, same-cycle write/start, and reset mid-run.
module tb_div_restoring;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] disp0, disp1, disp2, disp3;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    div_restoring_if #(.size(8)) bus ();

    div_restoring #(.size(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus),
        .disp0 (disp0),
        .disp1 (disp1),
        .disp2 (disp2),
        .disp3 (disp3)
    );

`ifdef DIV_HEX_DISPLAY_EN
    localparam logic [7:0] SEG_0 = 8'hC0;
    localparam logic [7:0] SEG_1 = 8'hF9;
    localparam logic [7:0] SEG_B = 8'h83;
    localparam logic [7:0] SEG_E = 8'h86;
`else
    localparam logic [7:0] SEG_0 = 8'hFF;
    localparam logic [7:0] SEG_1 = 8'hFF;
    localparam logic [7:0] SEG_B = 8'hFF;
    localparam logic [7:0] SEG_E = 8'hFF;
`endif

    typedef struct {
        logic [15:0] dvd;
        logic [7:0]  dvs;
        logic [15:0] q;
        logic [7:0]  r;
        logic        dbz;
        int          lat;
    } vec_t;

    vec_t vecs[7];

    // Compare one observed value against its expected value.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Write one operand register over the select-and-set bus.
    task automatic writeOperand(input logic [1:0] s, input logic [7:0] data);
        @(negedge clk);
        bus.set    = 1'b0;
        bus.sel    = s;
        bus.currIn = data;
        @(negedge clk);
        bus.set    = 1'b1;
        bus.sel    = 2'd3;
    endtask

    task automatic loadOperands(input logic [15:0] dvd, input logic [7:0] dvs);
        writeOperand(2'd0, dvd[7:0]);
        writeOperand(2'd1, dvd[15:8]);
        writeOperand(2'd2, dvs);
    endtask

    // Returns at the negedge of the cycle right after the sampling edge.
    task automatic pulseStart;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Wait (bounded) for done; lat counts cycles since start was asserted.
    task automatic waitDone(input int lat0, output int lat, output int busyCycles,
                            output int doneWidth, output logic busyAtDone,
                            output logic [15:0] q, output logic [7:0] r,
                            output logic dbz);
        lat        = lat0;
        busyCycles = 0;
        while (bus.done !== 1'b1 && lat < 40) begin
            if (bus.busy === 1'b1) busyCycles++;
            @(negedge clk);
            lat++;
        end
        busyAtDone = bus.busy;
        q          = bus.quotient;
        r          = bus.remainder;
        dbz        = bus.div_by_zero;
        doneWidth  = 0;
        while (bus.done === 1'b1 && doneWidth < 5) begin
            doneWidth++;
            @(negedge clk);
        end
    endtask

    // Load operands, start, and verify latency, handshake and results.
    task automatic applyStimulus(input vec_t v, input int idx);
        int lat, busyCycles, doneWidth;
        logic busyAtDone, dbz;
        logic [15:0] q;
        logic [7:0]  r;
        loadOperands(v.dvd, v.dvs);
        pulseStart();
        waitDone(1, lat, busyCycles, doneWidth, busyAtDone, q, r, dbz);
        checkOutput($sformatf("vec%0d latency", idx), lat, v.lat);
        checkOutput($sformatf("vec%0d busy_cycles", idx), busyCycles, v.lat - 1);
        checkOutput($sformatf("vec%0d busy_at_done", idx), busyAtDone, 1'b0);
        checkOutput($sformatf("vec%0d done_width", idx), doneWidth, 1);
        checkOutput($sformatf("vec%0d quotient", idx), q, v.q);
        checkOutput($sformatf("vec%0d remainder", idx), r, v.r);
        checkOutput($sformatf("vec%0d div_by_zero", idx), dbz, v.dbz);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat, busyCycles, doneWidth, extraDone;
        logic busyAtDone, dbz;
        logic [15:0] q;
        logic [7:0]  r;

        vecs[0] = '{16'h0C35, 8'h07, 16'h01BE, 8'h03, 1'b0, 17};
        vecs[1] = '{16'hFFFF, 8'h01, 16'hFFFF, 8'h00, 1'b0, 17};
        vecs[2] = '{16'h0005, 8'h09, 16'h0000, 8'h05, 1'b0, 17};
        vecs[3] = '{16'h8000, 8'h03, 16'h2AAA, 8'h02, 1'b0, 17};
        vecs[4] = '{16'h1234, 8'h00, 16'hFFFF, 8'h34, 1'b1, 1};
        vecs[5] = '{16'h0064, 8'h0A, 16'h000A, 8'h00, 1'b0, 17};
        vecs[6] = '{16'hFFFF, 8'hFF, 16'h0101, 8'h00, 1'b0, 17};

        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.set    = 1'b1;
        bus.sel    = 2'd3;
        bus.currIn = 8'h00;
        repeat (2) @(negedge clk);

        // Reset state.
        checkOutput("reset busy", bus.busy, 1'b0);
        checkOutput("reset done", bus.done, 1'b0);
        checkOutput("reset div_by_zero", bus.div_by_zero, 1'b0);
        checkOutput("reset quotient", bus.quotient, 16'h0000);
        checkOutput("reset remainder", bus.remainder, 8'h00);
        checkOutput("reset disp0", disp0, SEG_0);
        checkOutput("reset disp3", disp3, SEG_0);
        rst = 1'b0;

        // Table of directed divisions (vec5 also confirms dbz is cleared).
        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i], i);
            if (i == 0) begin
                checkOutput("disp0 nibble 0", disp0, SEG_0);
                checkOutput("disp1 nibble 1", disp1, SEG_1);
                checkOutput("disp2 nibble B", disp2, SEG_B);
                checkOutput("disp3 nibble E", disp3, SEG_E);
            end
        end

        // Start while busy and divisor rewrite mid-run are both ignored.
        loadOperands(16'h0C35, 8'h07);
        pulseStart();
        repeat (3) @(negedge clk);
        bus.start  = 1'b1;
        bus.set    = 1'b0;
        bus.sel    = 2'd2;
        bus.currIn = 8'h03;
        @(negedge clk);
        bus.start  = 1'b0;
        bus.set    = 1'b1;
        bus.sel    = 2'd3;
        waitDone(5, lat, busyCycles, doneWidth, busyAtDone, q, r, dbz);
        checkOutput("busy-start latency", lat, 17);
        checkOutput("busy-start quotient", q, 16'h01BE);
        checkOutput("busy-start remainder", r, 8'h03);
        checkOutput("busy-start done_width", doneWidth, 1);
        extraDone = 0;
        for (int k = 0; k < 20; k++) begin
            if (bus.done === 1'b1) extraDone++;
            @(negedge clk);
        end
        checkOutput("busy-start extra done", extraDone, 0);

        // The mid-run write did land in the operand register: 3125 / 3.
        pulseStart();
        waitDone(1, lat, busyCycles, doneWidth, busyAtDone, q, r, dbz);
        checkOutput("rewritten divisor quotient", q, 16'h0411);
        checkOutput("rewritten divisor remainder", r, 8'h02);

        // Write and start in the same cycle: start uses pre-write divisor.
        loadOperands(16'h0C35, 8'h07);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.set    = 1'b0;
        bus.sel    = 2'd2;
        bus.currIn = 8'h03;
        @(negedge clk);
        bus.start  = 1'b0;
        bus.set    = 1'b1;
        bus.sel    = 2'd3;
        waitDone(1, lat, busyCycles, doneWidth, busyAtDone, q, r, dbz);
        checkOutput("same-cycle latency", lat, 17);
        checkOutput("same-cycle quotient", q, 16'h01BE);
        checkOutput("same-cycle remainder", r, 8'h03);

        // Reset mid-run returns everything to idle/zero.
        loadOperands(16'hFFFF, 8'h01);
        pulseStart();
        repeat (6) @(negedge clk);
        checkOutput("pre-reset busy", bus.busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("mid-reset busy", bus.busy, 1'b0);
        checkOutput("mid-reset done", bus.done, 1'b0);
        checkOutput("mid-reset div_by_zero", bus.div_by_zero, 1'b0);
        checkOutput("mid-reset quotient", bus.quotient, 16'h0000);
        checkOutput("mid-reset remainder", bus.remainder, 8'h00);
        checkOutput("mid-reset disp1", disp1, SEG_0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("post-reset no done", bus.done, 1'b0);

        // Operands were cleared by reset: start now divides 0 by 0.
        pulseStart();
        waitDone(1, lat, busyCycles, doneWidth, busyAtDone, q, r, dbz);
        checkOutput("cleared operands latency", lat, 1);
        checkOutput("cleared operands quotient", q, 16'hFFFF);
        checkOutput("cleared operands remainder", r, 8'h00);
        checkOutput("cleared operands div_by_zero", dbz, 1'b1);

        // Reloaded operands give a correct result after reset.
        applyStimulus(vecs[0], 10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
